// File: rtl/pll_phase_ctrl.sv
// Bus-mapped PLL dynamic-phase / PLL-reset controller with per-counter signed offset tracking and boot preset.
// Bus ack one cycle after request; STEP writes stall (ack withheld) until the step engine is idle and boot is complete.
module pll_phase_ctrl #(
   parameter int NUM_CH       = 4,
   parameter int COUNTER_BASE = 2,
   parameter int EN_CYCLES    = 2,
   parameter int DONE_TIMEOUT = 1023,
   parameter int BOOT_CH      = 0,
   parameter int BOOT_STEPS   = 8,
   parameter int BOOT_UP      = 0
) (
   input  logic        system_clk,
   input  logic        system_reset_n,
   input  logic [27:0] hardware_addr,
   input  logic [31:0] hardware_data_in,
   output logic [31:0] hardware_data_out,
   input  logic [3:0]  hardware_data_sel,
   input  logic        hardware_write,
   input  logic        hardware_ready,
   output logic        hardware_ack,
   input  logic        pll_locked,
   input  logic        phase_done,
   output logic [4:0]  counter_sel,
   output logic        phase_enable,
   output logic        phase_up_down,
   output logic        pll_reset,
   output logic        boot_phase_done,
   output logic        busy
);
   localparam int TW = $clog2(DONE_TIMEOUT + 2);

   typedef enum logic [2:0] {S_IDLE, S_PULSE, S_WAIT_LOW, S_WAIT_HIGH, S_GAP} state_t;

   state_t        state_q, state_d;
   logic          lock_s1_q, lock_s1_d, lock_s2_q, lock_s2_d, lock_prev_q, lock_prev_d;
   logic          done_s1_q, done_s1_d, done_s2_q, done_s2_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    remaining_q, remaining_d;
   logic [3:0]    ch_q, ch_d;
   logic          up_q, up_d;
   logic [4:0]    counter_sel_q, counter_sel_d;
   logic          up_down_q, up_down_d;
   logic          phase_enable_q, phase_enable_d;
   logic          error_q, error_d;
   logic          boot_done_q, boot_done_d, boot_pend_q, boot_pend_d;
   logic          pll_reset_q, pll_reset_d, rst_req_q, rst_req_d;
   logic          ack_q, ack_d;
   logic [31:0]   data_out_q, data_out_d;
   logic [15:0]   offset_q [NUM_CH];
   logic [15:0]   offset_d [NUM_CH];

   logic [6:0]    addr;
   logic          lock_rise, lock_fall, idle_free, timed_out;
   logic          unused_ok;

   assign addr      = hardware_addr[6:0];
   assign lock_rise = lock_s2_q & ~lock_prev_q;
   assign lock_fall = ~lock_s2_q & lock_prev_q;
   assign idle_free = (state_q == S_IDLE) && (remaining_q == 8'd0) && boot_done_q && !lock_fall && !lock_rise;
   assign timed_out = (tmo_q == TW'(DONE_TIMEOUT));
   assign unused_ok = ^{hardware_data_sel, hardware_addr[27:7], hardware_data_in[31:16],
                        hardware_data_in[7:6], hardware_data_in[4]};

   always_comb begin
      state_d        = state_q;
      lock_s1_d      = pll_locked;
      lock_s2_d      = lock_s1_q;
      lock_prev_d    = lock_s2_q;
      done_s1_d      = phase_done;
      done_s2_d      = done_s1_q;
      cnt_d          = cnt_q;
      tmo_d          = tmo_q;
      remaining_d    = remaining_q;
      ch_d           = ch_q;
      up_d           = up_q;
      counter_sel_d  = counter_sel_q;
      up_down_d      = up_down_q;
      phase_enable_d = phase_enable_q;
      error_d        = error_q;
      boot_done_d    = boot_done_q;
      boot_pend_d    = boot_pend_q;
      pll_reset_d    = pll_reset_q;
      rst_req_d      = 1'b0;
      ack_d          = ack_q;
      data_out_d     = data_out_q;
      offset_d       = offset_q;

      case (state_q)
         S_IDLE: begin
            if (remaining_q != 8'd0) begin
               state_d       = S_PULSE;
               counter_sel_d = 5'(COUNTER_BASE) + {1'b0, ch_q};
               up_down_d     = up_q;
               cnt_d         = 4'd0;
            end
         end
         S_PULSE: begin
            if (cnt_q == 4'(EN_CYCLES - 1)) begin
               state_d = S_WAIT_LOW;
               tmo_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_WAIT_LOW, S_WAIT_HIGH: begin
            if ((state_q == S_WAIT_LOW) && !done_s2_q) begin
               state_d = S_WAIT_HIGH;
               tmo_d   = '0;
            end else if ((state_q == S_WAIT_HIGH) && done_s2_q) begin
               for (int i = 0; i < NUM_CH; i++) begin
                  if (ch_q == 4'(i)) offset_d[i] = up_down_q ? offset_q[i] + 16'd1 : offset_q[i] - 16'd1;
               end
               remaining_d = remaining_q - 8'd1;
               state_d     = (remaining_q > 8'd1) ? S_GAP : S_IDLE;
            end else if (timed_out) begin
               error_d     = 1'b1;
               remaining_d = 8'd0;
               state_d     = S_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_GAP: begin
            state_d = S_PULSE;
            cnt_d   = 4'd0;
         end
         default: state_d = S_IDLE;
      endcase

      if (boot_pend_q && (state_q != S_IDLE) && (state_d == S_IDLE)) begin
         boot_done_d = 1'b1;
         boot_pend_d = 1'b0;
      end

      // One transaction per ready pulse: ack drops only once ready has been released.
      if (ack_q) begin
         if (!hardware_ready) begin
            ack_d      = 1'b0;
            data_out_d = 32'd0;
         end
      end else if (hardware_ready) begin
         data_out_d = 32'd0;
         if (addr == 7'h00) begin
            if (!hardware_write) begin
               ack_d      = 1'b1;
               data_out_d = {boot_done_q, lock_s2_q, error_q, (state_q != S_IDLE), 12'd0, remaining_q, 8'd0};
            end else if (idle_free) begin
               ack_d = 1'b1;
               if ((hardware_data_in[15:8] != 8'd0) && ({1'b0, hardware_data_in[3:0]} < 5'(NUM_CH))) begin
                  remaining_d = hardware_data_in[15:8];
                  ch_d        = hardware_data_in[3:0];
                  up_d        = hardware_data_in[5];
               end
            end
         end else if (addr == 7'h01) begin
            ack_d = 1'b1;
            if (hardware_write) begin
               rst_req_d = hardware_data_in[0];
               if (hardware_data_in[1]) error_d = 1'b0;
            end
         end else begin
            ack_d = 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
               if (!hardware_write && (addr == 7'(16 + i))) data_out_d = {{16{offset_q[i][15]}}, offset_q[i]};
            end
         end
      end

      if (rst_req_q) begin
         pll_reset_d = 1'b1;
      end else if (pll_reset_q && !lock_s2_q) begin
         pll_reset_d = 1'b0;
      end

      if (lock_rise) begin
         remaining_d = 8'(BOOT_STEPS);
         ch_d        = 4'(BOOT_CH);
         up_d        = (BOOT_UP != 0);
         if (BOOT_STEPS == 0) boot_done_d = 1'b1;
         else                 boot_pend_d = 1'b1;
      end

      // Lock loss overrides everything except the sticky error flag.
      if (lock_fall) begin
         state_d     = S_IDLE;
         remaining_d = 8'd0;
         boot_done_d = 1'b0;
         boot_pend_d = 1'b0;
         cnt_d       = 4'd0;
         tmo_d       = '0;
         for (int i = 0; i < NUM_CH; i++) offset_d[i] = 16'd0;
      end

      phase_enable_d = (state_d == S_PULSE);
   end

   always_ff @(posedge system_clk or negedge system_reset_n) begin
      if (!system_reset_n) begin
         state_q        <= S_IDLE;
         lock_s1_q      <= 1'b0;
         lock_s2_q      <= 1'b0;
         lock_prev_q    <= 1'b0;
         done_s1_q      <= 1'b0;
         done_s2_q      <= 1'b0;
         cnt_q          <= 4'd0;
         tmo_q          <= '0;
         remaining_q    <= 8'd0;
         ch_q           <= 4'd0;
         up_q           <= 1'b1;
         counter_sel_q  <= 5'(COUNTER_BASE);
         up_down_q      <= 1'b1;
         phase_enable_q <= 1'b0;
         error_q        <= 1'b0;
         boot_done_q    <= 1'b0;
         boot_pend_q    <= 1'b0;
         pll_reset_q    <= 1'b0;
         rst_req_q      <= 1'b0;
         ack_q          <= 1'b0;
         data_out_q     <= 32'd0;
         for (int i = 0; i < NUM_CH; i++) offset_q[i] <= 16'd0;
      end else begin
         state_q        <= state_d;
         lock_s1_q      <= lock_s1_d;
         lock_s2_q      <= lock_s2_d;
         lock_prev_q    <= lock_prev_d;
         done_s1_q      <= done_s1_d;
         done_s2_q      <= done_s2_d;
         cnt_q          <= cnt_d;
         tmo_q          <= tmo_d;
         remaining_q    <= remaining_d;
         ch_q           <= ch_d;
         up_q           <= up_d;
         counter_sel_q  <= counter_sel_d;
         up_down_q      <= up_down_d;
         phase_enable_q <= phase_enable_d;
         error_q        <= error_d;
         boot_done_q    <= boot_done_d;
         boot_pend_q    <= boot_pend_d;
         pll_reset_q    <= pll_reset_d;
         rst_req_q      <= rst_req_d;
         ack_q          <= ack_d;
         data_out_q     <= data_out_d;
         offset_q       <= offset_d;
      end
   end

   assign hardware_data_out = data_out_q;
   assign hardware_ack      = ack_q;
   assign counter_sel       = counter_sel_q;
   assign phase_enable      = phase_enable_q;
   assign phase_up_down     = up_down_q;
   assign pll_reset         = pll_reset_q;
   assign boot_phase_done   = boot_done_q;
   assign busy              = (state_q != S_IDLE);
endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Randomised bench for pll_phase_ctrl: PLL handshake model, bus-level offset model and a per-cycle pulse monitor.
module tb_pll_phase_ctrl;
   localparam int NUM_CH = 4, COUNTER_BASE = 2, EN_CYCLES = 2, DONE_TIMEOUT = 1023;
   localparam int BOOT_CH = 0, BOOT_STEPS = 8, BOOT_UP = 0;

   logic        system_clk, system_reset_n;
   logic [27:0] hardware_addr;
   logic [31:0] hardware_data_in, hardware_data_out;
   logic [3:0]  hardware_data_sel;
   logic        hardware_write, hardware_ready, hardware_ack;
   logic        pll_locked, phase_done;
   logic [4:0]  counter_sel;
   logic        phase_enable, phase_up_down, pll_reset, boot_phase_done, busy;

   pll_phase_ctrl #(.NUM_CH(NUM_CH), .COUNTER_BASE(COUNTER_BASE), .EN_CYCLES(EN_CYCLES),
                    .DONE_TIMEOUT(DONE_TIMEOUT), .BOOT_CH(BOOT_CH), .BOOT_STEPS(BOOT_STEPS),
                    .BOOT_UP(BOOT_UP)) dut (
      .system_clk(system_clk), .system_reset_n(system_reset_n),
      .hardware_addr(hardware_addr), .hardware_data_in(hardware_data_in),
      .hardware_data_out(hardware_data_out), .hardware_data_sel(hardware_data_sel),
      .hardware_write(hardware_write), .hardware_ready(hardware_ready), .hardware_ack(hardware_ack),
      .pll_locked(pll_locked), .phase_done(phase_done), .counter_sel(counter_sel),
      .phase_enable(phase_enable), .phase_up_down(phase_up_down), .pll_reset(pll_reset),
      .boot_phase_done(boot_phase_done), .busy(busy));

   int checks = 0, errors = 0;
   int pll_mode = 0;      // 0 answers after done_lat cycles, 1 done stuck high, 2 done stuck low after a pulse
   int done_lat = 5;
   int pulse_total = 0, pe_len = 0;
   bit mon_en = 0;
   logic [4:0]  exp_sel;
   logic        exp_up;
   logic [15:0] exp_off [NUM_CH];
   logic        ack_busy;
   int          ack_pulses;

   initial system_clk = 1'b0;
   always #5 system_clk = ~system_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] sx(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

   function automatic logic [31:0] step_word(input int cnt, input int up, input int ch);
      logic [7:0] c;
      logic [3:0] h;
      c = 8'(cnt);
      h = 4'(ch);
      return {16'd0, c, 2'b00, (up != 0), 1'b0, h};
   endfunction

   // PLL phase handshake: done drops on each new phase_enable and recovers done_lat cycles later.
   initial begin
      bit pe_seen;
      int lat_cnt;
      pe_seen = 0;
      lat_cnt = 0;
      phase_done = 1'b1;
      forever begin
         @(posedge system_clk);
         #1;
         if (pll_mode == 1) begin
            phase_done = 1'b1;
         end else if (phase_enable && !pe_seen) begin
            pe_seen = 1;
            phase_done = 1'b0;
            lat_cnt = done_lat;
         end else if (!phase_done && pll_mode == 0) begin
            if (lat_cnt <= 1) phase_done = 1'b1;
            else lat_cnt--;
         end
         if (!phase_enable) pe_seen = 0;
      end
   end

   // Per-cycle compare: every strobe cycle must target the expected counter/direction while busy,
   // and every strobe must last exactly EN_CYCLES.
   always @(negedge system_clk) begin
      if (!mon_en) begin
         pe_len = 0;
      end else if (phase_enable) begin
         pe_len++;
         check("pe_sel", counter_sel, exp_sel);
         check("pe_dir", phase_up_down, exp_up);
         check("pe_busy", busy, 1);
      end else if (pe_len != 0) begin
         check("pe_len", pe_len, EN_CYCLES);
         pulse_total++;
         pe_len = 0;
      end
   end

   task automatic bus(input logic wr, input logic [6:0] a, input logic [31:0] wd, output logic [31:0] rd);
      int n;
      @(posedge system_clk);
      #1;
      hardware_addr = {21'd0, a};
      hardware_data_in = wd;
      hardware_write = wr;
      hardware_ready = 1'b1;
      n = 0;
      do begin
         @(negedge system_clk);
         n++;
      end while (!hardware_ack && n < 5000);
      check("bus_ack", hardware_ack, 1);
      rd = hardware_data_out;
      ack_busy = busy;
      ack_pulses = pulse_total;
      @(posedge system_clk);
      #1;
      hardware_ready = 1'b0;
      n = 0;
      do begin
         @(negedge system_clk);
         n++;
      end while (hardware_ack && n < 10);
      check("bus_ack_drop", hardware_ack, 0);
   endtask

   task automatic wait_idle(input int lim);
      int n;
      n = 0;
      while (busy && n < lim) begin
         @(negedge system_clk);
         n++;
      end
      check("wait_idle", busy, 0);
   endtask

   task automatic wait_boot();
      int n;
      n = 0;
      while (!boot_phase_done && n < 2000) begin
         @(negedge system_clk);
         n++;
      end
      check("boot_done", boot_phase_done, 1);
      check("boot_busy", busy, 0);
   endtask

   task automatic model_step(input int cnt, input int up, input int ch);
      if (ch < NUM_CH) exp_off[ch] = (up != 0) ? exp_off[ch] + 16'(cnt) : exp_off[ch] - 16'(cnt);
   endtask

   task automatic model_lock_loss();
      for (int i = 0; i < NUM_CH; i++) exp_off[i] = 16'd0;
   endtask

   task automatic check_all_offsets(input string name);
      logic [31:0] rd;
      for (int i = 0; i < NUM_CH; i++) begin
         bus(1'b0, 7'(16 + i), 32'd0, rd);
         check(name, rd, sx(exp_off[i]));
      end
   endtask

   task automatic do_boot();
      int base;
      exp_sel = 5'(COUNTER_BASE + BOOT_CH);
      exp_up = (BOOT_UP != 0);
      base = pulse_total;
      @(negedge system_clk);
      pll_locked = 1'b1;
      wait_boot();
      check("boot_pulses", pulse_total - base, BOOT_STEPS);
      model_step(BOOT_STEPS, BOOT_UP, BOOT_CH);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      int base, n, gap, cnt, up, ch;

      system_reset_n = 1'b1;
      pll_locked = 1'b0;
      hardware_addr = '0;
      hardware_data_in = '0;
      hardware_data_sel = 4'hF;
      hardware_write = 1'b0;
      hardware_ready = 1'b0;
      exp_sel = 5'(COUNTER_BASE + BOOT_CH);
      exp_up = (BOOT_UP != 0);
      model_lock_loss();
      #1 system_reset_n = 1'b0;
      #22;
      check("rst_counter_sel", counter_sel, COUNTER_BASE);
      check("rst_up_down", phase_up_down, 1);
      check("rst_outputs", {phase_enable, pll_reset, boot_phase_done, busy, hardware_ack}, 0);
      check("rst_data_out", hardware_data_out, 0);
      @(negedge system_clk);
      system_reset_n = 1'b1;
      mon_en = 1;
      repeat (3) @(negedge system_clk);

      // Boot preset: 8 down steps on channel 0
      do_boot();
      bus(1'b0, 7'h10, 32'd0, rd);
      check("boot_offset0", rd, 32'hFFFF_FFF8);

      // Single 3-step up request on channel 2
      exp_sel = 5'd4;
      exp_up = 1'b1;
      base = pulse_total;
      bus(1'b1, 7'h00, step_word(3, 1, 2), rd);
      gap = 0;
      n = 0;
      while (pulse_total - base < 3 && n < 500) begin
         @(negedge system_clk);
         if (!busy && pulse_total - base < 3) gap++;
         n++;
      end
      check("busy_gap", gap, 0);
      wait_idle(500);
      check("step3_pulses", pulse_total - base, 3);
      model_step(3, 1, 2);
      bus(1'b0, 7'h12, 32'd0, rd);
      check("step3_offset2", rd, 32'd3);
      bus(1'b0, 7'h00, 32'd0, rd);
      check("step3_remaining", rd[15:8], 0);
      check("step3_status", rd[31:28], 4'b1100);

      // Second STEP arrives while busy: must be held off until the engine is idle
      exp_sel = 5'(COUNTER_BASE + 1);
      exp_up = 1'b0;
      base = pulse_total;
      bus(1'b1, 7'h00, step_word(3, 0, 1), rd);
      bus(1'b1, 7'h00, step_word(1, 0, 1), rd);
      check("ack_while_busy", ack_busy, 0);
      check("ack_delay_pulses", ack_pulses - base, 3);
      wait_idle(500);
      check("queued_pulses", pulse_total - base, 4);
      model_step(4, 0, 1);
      bus(1'b0, 7'h11, 32'd0, rd);
      check("queued_offset1", rd, 32'hFFFF_FFFC);

      // Handshake timeout with done stuck high
      pll_mode = 1;
      exp_sel = 5'(COUNTER_BASE + 3);
      exp_up = 1'b1;
      bus(1'b1, 7'h00, step_word(2, 1, 3), rd);
      n = 0;
      while (busy && n < 3000) begin
         @(negedge system_clk);
         n++;
      end
      check("tmo_len", (n >= DONE_TIMEOUT && n <= DONE_TIMEOUT + 10), 1);
      bus(1'b0, 7'h00, 32'd0, rd);
      check("tmo_error", rd[29], 1);
      check("tmo_busy", rd[28], 0);
      check("tmo_remaining", rd[15:8], 0);
      bus(1'b0, 7'h13, 32'd0, rd);
      check("tmo_offset3", rd, sx(exp_off[3]));
      bus(1'b1, 7'h01, 32'h2, rd);
      bus(1'b0, 7'h00, 32'd0, rd);
      check("err_cleared", rd[29], 0);
      pll_mode = 0;

      // Randomised requests, including zero counts and out-of-range channels
      repeat (12) begin
         done_lat = $urandom_range(1, 8);
         cnt = $urandom_range(0, 5);
         up = $urandom_range(0, 1);
         ch = $urandom_range(0, 5);
         if (ch < NUM_CH) begin
            exp_sel = 5'(COUNTER_BASE + ch);
            exp_up = (up != 0);
         end
         base = pulse_total;
         bus(1'b1, 7'h00, step_word(cnt, up, ch), rd);
         wait_idle(2000);
         check("rand_pulses", pulse_total - base, (ch < NUM_CH) ? cnt : 0);
         model_step(cnt, up, ch);
         n = (ch < NUM_CH) ? ch : $urandom_range(0, NUM_CH - 1);
         bus(1'b0, 7'(16 + n), 32'd0, rd);
         check("rand_offset", rd, sx(exp_off[n]));
      end
      check_all_offsets("rand_all_offsets");
      done_lat = 5;

      // PLL reset request: held until lock drops, then offsets clear and boot reruns on relock
      bus(1'b1, 7'h01, 32'h1, rd);
      check("pll_reset_set", pll_reset, 1);
      repeat (5) @(negedge system_clk);
      check("pll_reset_hold", pll_reset, 1);
      pll_locked = 1'b0;
      model_lock_loss();
      n = 0;
      while (pll_reset && n < 20) begin
         @(negedge system_clk);
         n++;
      end
      check("pll_reset_clear", (n <= 4) && !pll_reset, 1);
      check("unlock_boot_done", boot_phase_done, 0);
      check_all_offsets("unlock_offsets");
      do_boot();
      bus(1'b0, 7'h10, 32'd0, rd);
      check("reboot_offset0", rd, sx(exp_off[0]));

      // Lock loss while waiting for done to return high
      pll_mode = 2;
      exp_sel = 5'(COUNTER_BASE + 1);
      exp_up = 1'b1;
      base = pulse_total;
      bus(1'b1, 7'h00, step_word(10, 1, 1), rd);
      n = 0;
      while (pulse_total - base < 1 && n < 200) begin
         @(negedge system_clk);
         n++;
      end
      repeat (10) @(negedge system_clk);
      check("stuck_busy", busy, 1);
      pll_locked = 1'b0;
      model_lock_loss();
      gap = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge system_clk);
         if (phase_enable) gap++;
      end
      check("drop_no_enable", gap, 0);
      check("drop_busy", busy, 0);
      bus(1'b0, 7'h00, 32'd0, rd);
      check("drop_remaining", rd[15:8], 0);
      check("drop_locked", rd[30], 0);
      bus(1'b0, 7'h11, 32'd0, rd);
      check("drop_offset1", rd, sx(exp_off[1]));
      bus(1'b0, 7'h7F, 32'd0, rd);
      check("read_7f", rd, 0);
      bus(1'b0, 7'(16 + NUM_CH), 32'd0, rd);
      check("read_bad_ch", rd, 0);
      pll_mode = 0;

      // Asynchronous reset in the middle of a step
      do_boot();
      exp_sel = 5'd4;
      exp_up = 1'b1;
      bus(1'b1, 7'h00, step_word(5, 1, 2), rd);
      n = 0;
      while (!phase_enable && n < 200) begin
         @(negedge system_clk);
         n++;
      end
      check("pre_arst_enable", phase_enable, 1);
      mon_en = 0;
      #2 system_reset_n = 1'b0;
      #1;
      check("arst_counter_sel", counter_sel, COUNTER_BASE);
      check("arst_up_down", phase_up_down, 1);
      check("arst_outputs", {phase_enable, pll_reset, boot_phase_done, busy}, 0);
      #20 system_reset_n = 1'b1;
      repeat (2) @(negedge system_clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pll_phase_ctrl.md
Name: pll_phase_ctrl

Overview:
- Bus-mapped controller for PLL dynamic phase shifting and PLL reset. It serves NUM_CH output counters, each with its own signed net-offset tracking.
- Accepts multi-step phase requests over the hardware bus and sequences them through the PLL phase_en/phase_done handshake with timeout.
- Runs a parametrised boot-time phase preset after every lock.
- Sits between the hardware bus decoder and the PLL reconfiguration pins. It generalises the single-step, single-counter phase/reset IO block.

Parameters:
- NUM_CH, 4, number of counters tracked (1..16).
- COUNTER_BASE, 2, counter_sel code of channel 0; channel n drives COUNTER_BASE+n.
- EN_CYCLES, 2, phase_enable high time in cycles (1..15).
- DONE_TIMEOUT, 1023, cycles allowed per handshake wait state before abort.
- BOOT_CH, 0, channel shifted at boot.
- BOOT_STEPS, 8, boot step count; 0 disables boot shifting.
- BOOT_UP, 0, boot direction (1 = up).

Ports:
- system_clk  in  1  clock
- system_reset_n  in  1  asynchronous active-low reset
- hardware_addr  in  28  bus address; bits [6:0] decoded
- hardware_data_in  in  32  write data
- hardware_data_out  out  32  read data, valid while hardware_ack
- hardware_data_sel  in  4  byte enables (ignored; full-word access)
- hardware_write  in  1  1 = write, 0 = read
- hardware_ready  in  1  request strobe, held until ack seen
- hardware_ack  out  1  request acknowledge
- pll_locked  in  1  PLL lock (asynchronous; 2-flop synchronised internally)
- phase_done  in  1  PLL phase handshake (2-flop synchronised)
- counter_sel  out  5  PLL counter select
- phase_enable  out  1  PLL phase step strobe
- phase_up_down  out  1  PLL direction (1 = up)
- pll_reset  out  1  PLL reset
- boot_phase_done  out  1  boot preset complete
- busy  out  1  step engine not IDLE

Behaviour:
- Reset: all outputs 0, except counter_sel = COUNTER_BASE and phase_up_down = 1. Offsets 0, error flag 0, engine IDLE.
- Register map (addr[6:0]):
  - 0x00 STEP: write {[15:8] count, [5] up, [3:0] ch}. Read = STATUS {[31] boot_done, [30] locked, [29] error, [28] busy, [15:8] remaining steps}.
  - 0x01 CTRL: write [0]=1 requests PLL reset; [1]=1 clears error. Read = 0.
  - 0x10+n, n<NUM_CH: read OFFSET n, sign-extended 16-bit net steps (up +1, down −1, 16-bit wraparound).
  - Any other address: ack, read 0, write ignored.
- Bus handshake:
  - On hardware_ready with ack low, decode and set ack next cycle.
  - Ack holds until hardware_ready falls, then clears the following cycle. One transaction per ready pulse.
  - STEP write while engine not IDLE or boot not done: ack withheld until engine IDLE and boot_phase_done=1, then accepted.
  - STEP with count=0 or ch>=NUM_CH: acked, no effect.
- Step engine states:
  - IDLE: if remaining>0 → PULSE. Load counter_sel = COUNTER_BASE+ch and phase_up_down, both stable for the whole step.
  - PULSE: phase_enable=1 for EN_CYCLES cycles → WAIT_LOW.
  - WAIT_LOW: wait for synced phase_done=0 → WAIT_HIGH.
  - WAIT_HIGH: wait for phase_done=1. Then update the channel offset and decrement remaining; → PULSE if remaining>0 after a 1-cycle gap, else IDLE.
  - Timeout: more than DONE_TIMEOUT cycles in WAIT_LOW or WAIT_HIGH sets error, zeroes remaining, → IDLE. The offset is not updated for that step.
  - busy = engine not IDLE.
- Boot sequence:
  - On rising synced pll_locked, load BOOT_CH/BOOT_STEPS/BOOT_UP into the engine.
  - boot_phase_done rises the cycle the engine returns to IDLE.
  - With BOOT_STEPS=0, boot_phase_done rises one cycle after lock.
- PLL reset:
  - A CTRL[0] write sets pll_reset the cycle after ack. pll_reset holds until synced pll_locked=0, then clears next cycle.
  - If pll_locked is already 0, pll_reset pulses for 1 cycle.
- Lock loss (synced pll_locked 1→0), at any time:
  - Engine aborts to IDLE immediately and phase_enable drops.
  - remaining, all offsets, and boot_phase_done clear; error is kept.
  - A pending STEP write stays un-acked until boot completes after relock.
- Simultaneous lock rise and STEP write: boot runs first; the write waits.
- Asynchronous reset mid-step: outputs return to reset values immediately.

Test Plan:
- Lock with BOOT_STEPS=8, BOOT_UP=0; PLL model answers done in 5 cycles → 8 phase_enable pulses of 2 cycles each on counter_sel=2, boot_phase_done=1, OFFSET0 reads 0xFFFFFFF8.
- Write STEP {count=3, up=1, ch=2} → counter_sel=4, 3 pulses, busy high throughout; OFFSET2=3; STATUS[15:8]=0 afterwards.
- Second STEP write while busy → ack delayed until IDLE, then 1 further pulse executes; OFFSET updated by both requests.
- PLL model holds phase_done=1 forever → timeout after 1023 cycles: error=1, busy=0, offset unchanged. CTRL write 0x2 clears error.
- CTRL write 0x1 → pll_reset high until pll_locked drops; offsets read 0; on relock boot reruns and boot_phase_done rises again.
- Drop pll_locked mid-WAIT_HIGH of a 10-step request → phase_enable=0 at once, remaining=0. Reads to 0x7F and ch>=NUM_CH return 0 with ack.
